// File: rtl/mem_view_sequencer_pkg.sv
// Shared constants and types for the memory-view sequencer and its
// downstream hex decoder consumers.
package mem_view_sequencer_pkg;

   localparam int MEM_DEPTH  = 32;
   localparam int MEM_ADDR_W = 5;

   // Dot outputs are active-low on the seven-segment board.
   localparam logic DOT_ON  = 1'b0;
   localparam logic DOT_OFF = 1'b1;

   typedef enum logic {
      ST_PAUSE = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

endpackage

// File: rtl/mem_view_sequencer_btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; a held level
// yields a single one-cycle pulse two edges after it is first sampled.
module mem_view_sequencer_btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pulse_o
);

   logic sync0_q;
   logic sync1_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync0_q <= 1'b0;
         sync1_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync0_q <= btn_i;
         sync1_q <= sync0_q;
         prev_q  <= sync1_q;
      end
   end

   assign pulse_o = sync1_q & ~prev_q;

endmodule

// File: rtl/mem_view_sequencer.sv
// Walks the memory address space (dwell timer or step button), tracks the
// read latency and presents address/data nibbles for three hex decoders.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_PAUSE | dwell counter held at 0; step edges advance the address
// ST_RUN   | dwell counter runs; address advances at each dwell expiry
module mem_view_sequencer
   import mem_view_sequencer_pkg::*;
#(
   parameter int DEPTH    = MEM_DEPTH,
   parameter int ADDR_W   = MEM_ADDR_W,
   parameter int DWELL    = 50_000_000,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_btn,
   input  logic              step_btn,
   input  logic [3:0]        mem_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        addr_hi_nib,
   output logic [3:0]        addr_lo_nib,
   output logic [3:0]        data_nib,
   output logic              data_dot,
   output logic              run_dot
);

   localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
   localparam logic [1:0]        LAT_LAST   = 2'(READ_LAT);

   state_e              state_q, state_d;
   logic [DW_W-1:0]     dwell_q, dwell_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0]          lat_q, lat_d;
   logic [3:0]          data_q, data_d;
   logic                ddot_q, ddot_d;
   logic                rdot_q, rdot_d;
   logic                run_pulse;
   logic                step_pulse;
   logic                advance;
   logic [7:0]          addr_ext;

   mem_view_sequencer_btn_edge u_run_edge (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (run_btn),
      .pulse_o (run_pulse)
   );

   mem_view_sequencer_btn_edge u_step_edge (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (step_btn),
      .pulse_o (step_pulse)
   );

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      addr_d  = addr_q;
      lat_d   = lat_q;
      data_d  = data_q;
      ddot_d  = ddot_q;
      advance = 1'b0;

      if (state_q == ST_RUN) begin
         if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            advance = 1'b1;
         end else begin
            dwell_d = dwell_q + 1'b1;
         end
      end else begin
         dwell_d = '0;
         advance = step_pulse & ~run_pulse;
      end

      // A toggle always restarts the dwell; an expiry on the same edge still advances.
      if (run_pulse) begin
         state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
         dwell_d = '0;
      end

      if (advance) begin
         addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
         lat_d  = '0;
         ddot_d = DOT_ON;
      end else if (ddot_q == DOT_ON) begin
         if (lat_q + 2'd1 == LAT_LAST) begin
            data_d = mem_data;
            ddot_d = DOT_OFF;
            lat_d  = '0;
         end else begin
            lat_d = lat_q + 2'd1;
         end
      end

      rdot_d = (state_d == ST_RUN) ? DOT_ON : DOT_OFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_PAUSE;
         dwell_q <= '0;
         addr_q  <= '0;
         lat_q   <= '0;
         data_q  <= 4'h0;
         ddot_q  <= DOT_ON;
         rdot_q  <= DOT_OFF;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         addr_q  <= addr_d;
         lat_q   <= lat_d;
         data_q  <= data_d;
         ddot_q  <= ddot_d;
         rdot_q  <= rdot_d;
      end
   end

   assign addr_ext    = 8'(addr_q);
   assign mem_addr    = addr_q;
   assign addr_hi_nib = addr_ext[7:4];
   assign addr_lo_nib = addr_ext[3:0];
   assign data_nib    = data_q;
   assign data_dot    = ddot_q;
   assign run_dot     = rdot_q;

endmodule

// File: tb/tb_mem_view_sequencer.sv
// Directed bench for mem_view_sequencer with a short dwell and a memory
// whose data for an address is valid in the cycle after it is issued.
module tb_mem_view_sequencer;

   logic       clk;
   logic       rst;
   logic       run_btn;
   logic       step_btn;
   logic [3:0] mem_data;
   logic [4:0] mem_addr;
   logic [3:0] addr_hi_nib;
   logic [3:0] addr_lo_nib;
   logic [3:0] data_nib;
   logic       data_dot;
   logic       run_dot;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       rst;
      logic       run;
      logic       step;
      logic [4:0] addr;
      logic       rdot;
      logic       ddot;
      logic [3:0] data;
   } vec_t;

   vec_t vecs[$];

   mem_view_sequencer #(
      .DWELL    (4),
      .READ_LAT (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .run_btn     (run_btn),
      .step_btn    (step_btn),
      .mem_data    (mem_data),
      .mem_addr    (mem_addr),
      .addr_hi_nib (addr_hi_nib),
      .addr_lo_nib (addr_lo_nib),
      .data_nib    (data_nib),
      .data_dot    (data_dot),
      .run_dot     (run_dot)
   );

   assign mem_data = mem_addr[3:0] ^ 4'hA;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic add(input logic r, input logic rn, input logic st, input logic [4:0] a,
                      input logic rd, input logic dd, input logic [3:0] d);
      vec_t v;
      v.rst = r; v.run = rn; v.step = st;
      v.addr = a; v.rdot = rd; v.ddot = dd; v.data = d;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int found;
      rst = 1'b1; run_btn = 1'b0; step_btn = 1'b0;

      // rst run step | addr run_dot data_dot data
      add(1, 0, 0, 0, 1, 0, 4'h0);
      for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 1, 1, 4'hA);
      add(0, 1, 0, 0, 1, 1, 4'hA);
      add(0, 1, 0, 0, 1, 1, 4'hA);
      add(0, 1, 0, 0, 0, 1, 4'hA);
      add(0, 0, 0, 0, 0, 1, 4'hA);
      add(0, 0, 0, 0, 0, 1, 4'hA);
      add(0, 0, 0, 0, 0, 1, 4'hA);
      add(0, 0, 0, 1, 0, 0, 4'hA);
      add(0, 0, 0, 1, 0, 1, 4'hB);
      add(0, 0, 0, 1, 0, 1, 4'hB);
      add(0, 0, 0, 1, 0, 1, 4'hB);
      add(0, 0, 0, 2, 0, 0, 4'hB);
      add(0, 0, 0, 2, 0, 1, 4'h8);
      add(0, 1, 0, 2, 0, 1, 4'h8);
      add(0, 1, 0, 2, 0, 1, 4'h8);
      add(0, 1, 0, 3, 1, 0, 4'h8);
      add(0, 0, 0, 3, 1, 1, 4'h9);
      add(0, 0, 0, 3, 1, 1, 4'h9);
      add(0, 0, 0, 3, 1, 1, 4'h9);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; run_btn = vecs[i].run; step_btn = vecs[i].step;
         tick();
         chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
         chk($sformatf("v%0d addr_lo_nib", i), addr_lo_nib, vecs[i].addr[3:0]);
         chk($sformatf("v%0d addr_hi_nib", i), addr_hi_nib, {3'b000, vecs[i].addr[4]});
         chk($sformatf("v%0d run_dot", i), run_dot, vecs[i].rdot);
         chk($sformatf("v%0d data_dot", i), data_dot, vecs[i].ddot);
         chk($sformatf("v%0d data_nib", i), data_nib, vecs[i].data);
      end

      // Held step in PAUSE: one advance only
      step_btn = 1'b1;
      repeat (20) tick();
      chk("step_hold addr", mem_addr, 4);
      chk("step_hold data", data_nib, 4'hE);
      step_btn = 1'b0;
      repeat (3) tick();

      // Single short step pulse
      step_btn = 1'b1;
      tick();
      step_btn = 1'b0;
      repeat (4) tick();
      chk("step_pulse addr", mem_addr, 5);

      // Run and step together: toggle wins, full dwell before first advance
      run_btn = 1'b1; step_btn = 1'b1;
      tick();
      run_btn = 1'b0; step_btn = 1'b0;
      tick();
      tick();
      chk("run+step run_dot", run_dot, 0);
      chk("run+step addr", mem_addr, 5);
      step_btn = 1'b1;
      tick();
      step_btn = 1'b0;
      tick();
      tick();
      chk("step_in_run addr", mem_addr, 5);
      tick();
      chk("first_expiry addr", mem_addr, 6);
      chk("first_expiry data_dot", data_dot, 0);

      // Wrap 31 -> 0
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         tick();
         if (mem_addr == 5'd31) found = 1;
      end
      chk("reach_31", found, 1);
      chk("addr31 hi", addr_hi_nib, 1);
      chk("addr31 lo", addr_lo_nib, 4'hF);
      repeat (3) tick();
      chk("addr31 hold", mem_addr, 31);
      tick();
      chk("wrap addr", mem_addr, 0);
      chk("wrap hi", addr_hi_nib, 0);
      chk("wrap lo", addr_lo_nib, 0);

      // Reset with a read pending while running
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         tick();
         if (mem_addr == 5'd9) found = 1;
      end
      chk("reach_9", found, 1);
      chk("addr9 pending", data_dot, 0);
      rst = 1'b1;
      tick();
      chk("rst addr", mem_addr, 0);
      chk("rst run_dot", run_dot, 1);
      chk("rst data_dot", data_dot, 0);
      chk("rst data_nib", data_nib, 0);
      rst = 1'b0;
      tick();
      chk("post_rst data_dot", data_dot, 1);
      chk("post_rst data_nib", data_nib, 4'hA);
      repeat (8) tick();
      chk("post_rst paused addr", mem_addr, 0);
      chk("post_rst run_dot", run_dot, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
